// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_tx_state_t   - transmitter FSM states
//   CLKS_PER_BAUD_DEF - default clocks per serial bit, common to both directions
package uart_pkg;

    localparam int CLKS_PER_BAUD_DEF = 1041;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter.
//   clk       in  system clock
//   nRst      in  synchronous active-low reset
//   clr_i     in  hold the count at zero
//   bit_end_o out high during the last clock of each bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = CLKS_PER_BAUD_DEF
) (
    input  logic clk,
    input  logic nRst,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CW = (CLKS_PER_BAUD > 2) ? $clog2(CLKS_PER_BAUD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_o = (cnt_q == CW'(CLKS_PER_BAUD - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || bit_end_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!nRst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, 8 data bits LSB first, idle high,
// optional even parity, one or two stop bits, one-byte holding buffer.
//   clk       in  system clock
//   nRst      in  synchronous active-low reset
//   tx_valid  in  tx_data valid for transfer
//   tx_data   in  byte to transmit
//   tx_ready  out holding buffer can accept a byte
//   tx_serial out registered serial line
//   tx_busy   out a frame is on the line
//   tx_done   out one-cycle pulse after each frame's final stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = CLKS_PER_BAUD_DEF,
    parameter int PARITY_EN     = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_tx_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] buf_q, buf_d;
    logic       full_q, full_d;
    logic       par_q, par_d;
    logic [2:0] idx_q, idx_d;
    logic       serial_q, serial_d;
    logic       done_q, done_d;
    logic       bit_end;
    logic       xfer;
    logic       direct;

    uart_baud_gen #(.CLKS_PER_BAUD(CLKS_PER_BAUD)) u_baud (
        .clk      (clk),
        .nRst     (nRst),
        .clr_i    (state_q == IDLE),
        .bit_end_o(bit_end)
    );

    // ready comes straight from the buffer flag register
    assign tx_ready  = ~full_q;
    assign xfer      = tx_valid && !full_q;
    assign tx_serial = serial_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = done_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        buf_d    = buf_q;
        full_d   = full_q;
        par_d    = par_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        direct   = 1'b0;
        serial_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    direct  = 1'b1;
                    shift_d = tx_data;
                    par_d   = ^tx_data;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == 3'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        if (full_q) begin
                            // drain the buffer with no idle gap
                            shift_d = buf_q;
                            par_d   = ^buf_q;
                            full_d  = 1'b0;
                            state_d = START;
                        end else if (xfer) begin
                            direct  = 1'b1;
                            shift_d = tx_data;
                            par_d   = ^tx_data;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // any other accepted byte queues behind the active frame
        if (xfer && !direct) begin
            buf_d  = tx_data;
            full_d = 1'b1;
        end

        // line level follows the next state so the output stays registered
        unique case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            buf_q    <= '0;
            full_q   <= 1'b0;
            par_q    <= 1'b0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            buf_q    <= buf_d;
            full_q   <= full_d;
            par_q    <= par_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLKS_PER_BAUD=4.
// Instance 0: 8N1, instance 1: 8E1, instance 2: 8N2.
module tb_uart_tx;

    logic       clk;
    logic       nRst;
    logic       v   [3];
    logic [7:0] d   [3];
    logic       rdy [3];
    logic       ser [3];
    logic       bsy [3];
    logic       dn  [3];

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(.CLKS_PER_BAUD(4), .PARITY_EN(0), .STOP_BITS(1)) u0 (
        .clk(clk), .nRst(nRst), .tx_valid(v[0]), .tx_data(d[0]),
        .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
    uart_tx #(.CLKS_PER_BAUD(4), .PARITY_EN(1), .STOP_BITS(1)) u1 (
        .clk(clk), .nRst(nRst), .tx_valid(v[1]), .tx_data(d[1]),
        .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
    uart_tx #(.CLKS_PER_BAUD(4), .PARITY_EN(0), .STOP_BITS(2)) u2 (
        .clk(clk), .nRst(nRst), .tx_valid(v[2]), .tx_data(d[2]),
        .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called 1ns after an edge; the transfer happens at the next edge
    task automatic send(input int i, input logic [7:0] b);
        v[i] = 1'b1;
        d[i] = b;
        tick();
        v[i] = 1'b0;
        d[i] = ~b;
    endtask

    // fr holds the frame bits, bit 0 = start bit. Entered 1ns after the
    // frame's first edge; optionally queues qb during cycle q_at.
    task automatic run_frame(input int i, input logic [11:0] fr, input int nb,
                             input int q_at, input logic [7:0] qb);
        for (int j = 0; j < nb * 4; j++) begin
            chk("serial", ser[i], fr[j/4]);
            chk("busy", bsy[i], 1'b1);
            if (j > 0) chk("done_low", dn[i], 1'b0);
            chk("ready", rdy[i], !(q_at >= 0 && j > q_at));
            if (j == q_at) begin
                v[i] = 1'b1;
                d[i] = qb;
            end
            tick();
            if (j == q_at) begin
                v[i] = 1'b0;
                d[i] = 8'h00;
            end
        end
        chk("done_pulse", dn[i], 1'b1);
    endtask

    logic [7:0] got [4];
    logic [7:0] exp_stream [4];

    initial begin
        nRst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0;
            d[i] = 8'h00;
        end
        repeat (3) tick();
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", rdy[i], 1'b1);
            chk("rst_serial", ser[i], 1'b1);
            chk("rst_busy", bsy[i], 1'b0);
            chk("rst_done", dn[i], 1'b0);
        end
        tick();

        // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
        send(0, 8'hA5);
        run_frame(0, 12'h34A, 10, -1, 8'h00);
        tick();
        chk("a5_idle_busy", bsy[0], 1'b0);
        chk("a5_idle_ser", ser[0], 1'b1);
        chk("a5_done_once", dn[0], 1'b0);
        repeat (3) tick();

        // back-to-back 0x00 then 0xFF queued during DATA
        send(0, 8'h00);
        run_frame(0, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 14, 8'hFF);
        run_frame(0, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, -1, 8'h00);
        tick();
        chk("b2b_idle", bsy[0], 1'b0);
        repeat (2) tick();

        // even parity: 0x07 -> 1, 0x03 -> 0; 11 bits = 44 cycles
        send(1, 8'h07);
        run_frame(1, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 8'h00);
        tick();
        chk("par07_idle", bsy[1], 1'b0);
        send(1, 8'h03);
        run_frame(1, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1, 8'h00);
        tick();
        chk("par03_idle", bsy[1], 1'b0);

        // two stop bits, 0x55
        send(2, 8'h55);
        run_frame(2, {1'b0, 2'b11, 8'h55, 1'b0}, 11, -1, 8'h00);
        tick();
        chk("stop2_idle", bsy[2], 1'b0);
        repeat (2) tick();

        // reset during data bit 3 (frame bit 4 = cycles 16..19)
        send(0, 8'h99);
        repeat (17) tick();
        chk("pre_rst_busy", bsy[0], 1'b1);
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        chk("mid_rst_serial", ser[0], 1'b1);
        chk("mid_rst_busy", bsy[0], 1'b0);
        chk("mid_rst_ready", rdy[0], 1'b1);
        chk("mid_rst_done", dn[0], 1'b0);
        tick();
        chk("post_rst_ser", ser[0], 1'b1);
        send(0, 8'h3C);
        run_frame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, -1, 8'h00);
        repeat (4) tick();

        // streaming: data at edge c is c*3+7; transfers land at edges 0,1,41,81
        exp_stream[0] = 8'd7;
        exp_stream[1] = 8'd10;
        exp_stream[2] = 8'd130;
        exp_stream[3] = 8'd250;
        fork
            begin
                v[0] = 1'b1;
                d[0] = 8'd7;
                for (int c = 0; c <= 81; c++) begin
                    tick();
                    d[0] = 8'(c * 3 + 10);
                end
                v[0] = 1'b0;
            end
            begin
                for (int f = 0; f < 4; f++) begin
                    int w;
                    w = 0;
                    while (ser[0] !== 1'b0 && w < 200) begin
                        tick();
                        w++;
                    end
                    chk("stream_start_seen", (w < 200), 1'b1);
                    got[f] = 8'h00;
                    repeat (2) tick();
                    chk("stream_start_mid", ser[0], 1'b0);
                    for (int k = 0; k < 8; k++) begin
                        repeat (4) tick();
                        got[f][k] = ser[0];
                    end
                    repeat (4) tick();
                    chk("stream_stop", ser[0], 1'b1);
                    chk("stream_byte", got[f], exp_stream[f]);
                end
            end
        join
        repeat (3) tick();
        chk("stream_end_busy", bsy[0], 1'b0);
        chk("stream_end_ready", rdy[0], 1'b1);
        begin
            int lows;
            lows = 0;
            for (int c = 0; c < 60; c++) begin
                if (ser[0] !== 1'b1) lows++;
                tick();
            end
            chk("stream_no_extra", lows, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
